// File: rtl/game_pkg.sv
// Shared definitions for the game timer: FSM state encoding and BCD range.
// Ports: none (package only).
// Imported by game_timer and bin_to_bcd2.
package game_pkg;

    typedef enum logic [1:0] {
        TIMER_IDLE    = 2'd0,
        TIMER_RUN     = 2'd1,
        TIMER_PAUSE   = 2'd2,
        TIMER_EXPIRED = 2'd3
    } timer_state_t;

    // Largest value representable by two BCD digits.
    localparam int BCD_MAX = 99;

endpackage

// File: rtl/bin_to_bcd2.sv
// Combinational binary to two-digit BCD converter, valid for 0..99.
// Ports: bin (WIDTH-bit value) -> tens, ones (4-bit BCD digits).
// Inputs above 99 saturate to 9/9 so the display never shows a non-decimal digit.
module bin_to_bcd2
    import game_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    logic [31:0] value;

    always_comb begin
        value = 32'(bin);
        if (value > 32'(BCD_MAX)) begin
            tens = 4'd9;
            ones = 4'd9;
        end else begin
            tens = 4'(value / 32'd10);
            ones = 4'(value % 32'd10);
        end
    end

endmodule

// File: rtl/game_timer.sv
// Up/down game-time counter on the 1 Hz clock with load, pause, wrap/stop and run-status FSM.
// Ports: clk_1H, reset (sync, active-low), game_start, game_on, dir, load, load_val
//        -> count_out, bcd_tens, bcd_ones, wrap_pulse, expired, running.
module game_timer
    import game_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int MAX_COUNT   = 29,
    parameter int AUTO_RELOAD = 1
) (
    input  logic             clk_1H,
    input  logic             reset,
    input  logic             game_start,
    input  logic             game_on,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             wrap_pulse,
    output logic             expired,
    output logic             running
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    timer_state_t     state;
    timer_state_t     state_nxt;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] clamped;
    logic             en;
    logic             advance;
    logic             terminal;
    logic             stop_step;
    logic             wrap_step;

    assign en      = game_start && game_on;
    assign advance = en && (state != TIMER_EXPIRED) && !load;
    assign clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // A count above MAX_COUNT can only come from a misconfiguration; it is
    // treated as terminal in either direction so the counter recovers.
    assign terminal  = (count > MAX_V) || (dir ? (count == '0) : (count == MAX_V));
    assign stop_step = advance && terminal && (AUTO_RELOAD == 0);
    assign wrap_step = advance && terminal && (AUTO_RELOAD != 0);

    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = clamped;
        end else if (wrap_step) begin
            count_nxt = dir ? MAX_V : '0;
        end else if (advance && !terminal) begin
            count_nxt = dir ? (count - WIDTH'(1)) : (count + WIDTH'(1));
        end
        // stop_step: count parks on its terminal value.
    end

    always_ff @(posedge clk_1H) begin
        if (!reset) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            count      <= count_nxt;
            wrap_pulse <= wrap_step;
        end
    end

    // FSM state register
    always_ff @(posedge clk_1H) begin
        if (!reset) begin
            state <= TIMER_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state. Load leaves the state alone except to release EXPIRED.
    // A stopping terminal step can happen from IDLE or PAUSE too, because the
    // first advance happens on the same edge that leaves those states.
    always_comb begin
        state_nxt = state;
        if (load) begin
            if (state == TIMER_EXPIRED) begin
                state_nxt = TIMER_IDLE;
            end
        end else if (stop_step) begin
            state_nxt = TIMER_EXPIRED;
        end else begin
            case (state)
                TIMER_IDLE: begin
                    if (en) state_nxt = TIMER_RUN;
                end
                TIMER_RUN: begin
                    if (!game_start)   state_nxt = TIMER_IDLE;
                    else if (!game_on) state_nxt = TIMER_PAUSE;
                end
                TIMER_PAUSE: begin
                    if (en)               state_nxt = TIMER_RUN;
                    else if (!game_start) state_nxt = TIMER_IDLE;
                end
                TIMER_EXPIRED: begin
                    state_nxt = TIMER_EXPIRED;
                end
                default: begin
                    state_nxt = TIMER_IDLE;
                end
            endcase
        end
    end

    // FSM outputs, decoded from the state register
    always_comb begin
        running = (state == TIMER_RUN);
        expired = (state == TIMER_EXPIRED);
    end

    assign count_out = count;

    bin_to_bcd2 #(
        .WIDTH (WIDTH)
    ) u_bcd (
        .bin  (count),
        .tens (bcd_tens),
        .ones (bcd_ones)
    );

endmodule
